// File: rtl/wasm_run_ctrl.sv
// wasm_run_ctrl: run controller and watchdog that sequences, times and classifies runs of one WASM core
module wasm_run_ctrl #(
  parameter int RST_CYCLES   = 4,
  parameter int TIMEOUT      = 500,
  parameter int CNT_W        = 16,
  parameter int NUM_RUNS     = 1,
  parameter int RUN_W        = 8,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_instr_finish,
  input  logic             i_instr_error,
  input  logic             i_stack_full,
  output logic             o_core_rst_n,
  output logic             o_busy,
  output logic             o_run_valid,
  output logic [1:0]       o_status,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [RUN_W-1:0] o_run_index,
  output logic [RUN_W-1:0] o_pass_count,
  output logic [RUN_W-1:0] o_fail_count,
  output logic             o_done
);
  typedef enum logic [1:0] {IDLE, RESET, RUN, FIN} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic hit, last, stop;
  logic [1:0] outcome;
  // run outcome with priority error > stack_full > finish, timeout only when nothing else fires
  always_comb begin
    hit = i_instr_error | i_stack_full | i_instr_finish | (cnt == CNT_W'(TIMEOUT - 1));
    outcome = i_instr_error ? 2'd1 : i_stack_full ? 2'd2 : i_instr_finish ? 2'd0 : 2'd3;
    last = o_run_index == RUN_W'(NUM_RUNS - 1);
    stop = (STOP_ON_FAIL != 0) && (o_status != 2'd0);
  end
  // sequencer: core reset window, timed run, one-cycle end state, then next run or done
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      o_core_rst_n <= 1'b0;
      o_busy <= 1'b0;
      o_run_valid <= 1'b0;
      o_status <= 2'd0;
      o_cycle_count <= '0;
      o_run_index <= '0;
      o_pass_count <= '0;
      o_fail_count <= '0;
      o_done <= 1'b0;
    end else begin
      o_run_valid <= 1'b0;
      o_done <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          state <= RESET;
          cnt <= '0;
          o_busy <= 1'b1;
          o_run_index <= '0;
          o_pass_count <= '0;
          o_fail_count <= '0;
        end
        RESET: if (cnt == CNT_W'(RST_CYCLES - 1)) begin
          state <= RUN;
          cnt <= '0;
          o_core_rst_n <= 1'b1;
        end else cnt <= cnt + 1'b1;
        RUN: if (hit) begin
          state <= FIN;
          o_core_rst_n <= 1'b0;
          o_busy <= 1'b0;
          o_run_valid <= 1'b1;
          o_status <= outcome;
          o_cycle_count <= cnt + 1'b1;
          if (outcome == 2'd0) o_pass_count <= o_pass_count + RUN_W'(~&o_pass_count);
          else o_fail_count <= o_fail_count + RUN_W'(~&o_fail_count);
        end else cnt <= (&cnt) ? cnt : cnt + 1'b1;
        FIN: if (last || stop) begin
          state <= IDLE;
          o_done <= 1'b1;
        end else begin
          state <= RESET;
          cnt <= '0;
          o_busy <= 1'b1;
          o_run_index <= o_run_index + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wasm_run_ctrl.sv
// tb_wasm_run_ctrl: randomized and directed checks of two run controllers (finish-all and stop-on-fail)
module tb_wasm_run_ctrl;
  logic clk = 0, rst = 1, start = 0, fin = 0, err = 0, stk = 0;
  logic a_rst_n, a_busy, a_rv, a_done, b_rst_n, b_busy, b_rv, b_done;
  logic [1:0] a_st, b_st;
  logic [15:0] a_cc, b_cc;
  logic [7:0] a_ri, a_pc, a_fc, b_ri, b_pc, b_fc;
  int checks = 0, failures = 0;
  logic [2:0] kind [3];
  int cyc [3];
  always #5 clk = ~clk;
  wasm_run_ctrl #(.RST_CYCLES(4), .TIMEOUT(20), .CNT_W(16), .NUM_RUNS(3), .RUN_W(8), .STOP_ON_FAIL(0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_instr_finish(fin), .i_instr_error(err),
    .i_stack_full(stk), .o_core_rst_n(a_rst_n), .o_busy(a_busy), .o_run_valid(a_rv),
    .o_status(a_st), .o_cycle_count(a_cc), .o_run_index(a_ri), .o_pass_count(a_pc),
    .o_fail_count(a_fc), .o_done(a_done));
  wasm_run_ctrl #(.RST_CYCLES(4), .TIMEOUT(20), .CNT_W(16), .NUM_RUNS(3), .RUN_W(8), .STOP_ON_FAIL(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_instr_finish(fin), .i_instr_error(err),
    .i_stack_full(stk), .o_core_rst_n(b_rst_n), .o_busy(b_busy), .o_run_valid(b_rv),
    .o_status(b_st), .o_cycle_count(b_cc), .o_run_index(b_ri), .o_pass_count(b_pc),
    .o_fail_count(b_fc), .o_done(b_done));

  task automatic run_seq(input bit poke);
    int n, ecnt, est, pa, fa, pb, fb, bst, bcc;
    bit b_on;
    pa = 0; fa = 0; pb = 0; fb = 0; b_on = 1; est = 0; ecnt = 0; bst = 0; bcc = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int r = 0; r < 3; r++) begin
      if (r == 0) begin
        checks++;
        if (a_pc !== 0 || a_fc !== 0 || a_busy !== 1 || b_busy !== 1) begin
          failures++; $display("FAIL start_clear pass=%0d fail=%0d busy=%b/%b want 0 0 1/1", a_pc, a_fc, a_busy, b_busy);
        end
      end
      n = 0;
      while (a_rst_n === 1'b0 && n < 50) begin n++; @(negedge clk); end
      checks++;
      if (n != 4 || (b_on && b_rst_n !== 1)) begin
        failures++; $display("FAIL rst_low run=%0d low_cycles=%0d b_rst_n=%b want 4 and 1", r, n, b_rst_n);
      end
      ecnt = (kind[r] == 0 || cyc[r] > 20) ? 20 : cyc[r];
      est = (kind[r] == 0 || cyc[r] > 20) ? 3 : kind[r][2] ? 1 : kind[r][1] ? 2 : 0;
      for (int i = 1; i <= ecnt; i++) begin
        err = (i == cyc[r]) && kind[r][2];
        stk = (i == cyc[r]) && kind[r][1];
        fin = (i == cyc[r]) && kind[r][0];
        start = poke && r == 0 && i == 2;
        checks++;
        if (a_rv !== 0 || a_busy !== 1 || a_rst_n !== 1) begin
          failures++; $display("FAIL run_phase run=%0d cyc=%0d rv=%b busy=%b rst_n=%b want 0 1 1", r, i, a_rv, a_busy, a_rst_n);
        end
        @(negedge clk);
      end
      err = 0; stk = 0; fin = 0; start = 0;
      if (est == 0) pa++; else fa++;
      checks++;
      if (a_rv !== 1 || a_st !== est[1:0] || a_cc !== ecnt[15:0] || a_pc !== pa[7:0] || a_fc !== fa[7:0] ||
          a_ri !== r[7:0] || a_rst_n !== 0 || a_busy !== 0) begin
        failures++;
        $display("FAIL a_end run=%0d rv=%b st=%0d cc=%0d pc=%0d fc=%0d ri=%0d rst_n=%b busy=%b want 1 %0d %0d %0d %0d %0d 0 0",
                 r, a_rv, a_st, a_cc, a_pc, a_fc, a_ri, a_rst_n, a_busy, est, ecnt, pa, fa, r);
      end
      checks++;
      if (b_on) begin
        if (est == 0) pb++; else fb++;
        bst = est; bcc = ecnt;
        if (b_rv !== 1 || b_st !== est[1:0] || b_cc !== ecnt[15:0] || b_pc !== pb[7:0] || b_fc !== fb[7:0] || b_ri !== r[7:0]) begin
          failures++;
          $display("FAIL b_end run=%0d rv=%b st=%0d cc=%0d pc=%0d fc=%0d ri=%0d want 1 %0d %0d %0d %0d %0d",
                   r, b_rv, b_st, b_cc, b_pc, b_fc, b_ri, est, ecnt, pb, fb, r);
        end
      end else if (b_rv !== 0 || b_busy !== 0) begin
        failures++; $display("FAIL b_idle run=%0d rv=%b busy=%b want 0 0", r, b_rv, b_busy);
      end
      @(negedge clk);
      checks++;
      if (a_done !== (r == 2) || a_rv !== 0) begin
        failures++; $display("FAIL a_done run=%0d done=%b rv=%b want %b 0", r, a_done, a_rv, r == 2);
      end
      if (b_on) begin
        checks++;
        if (b_done !== (r == 2 || est != 0)) begin
          failures++; $display("FAIL b_done run=%0d done=%b want %b", r, b_done, r == 2 || est != 0);
        end
        if (est != 0) b_on = 0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      fin = 1; err = i[0]; stk = 1;
      @(negedge clk);
      checks++;
      if (a_done !== 0 || a_rv !== 0 || a_busy !== 0 || a_st !== est[1:0] || a_cc !== ecnt[15:0] || a_pc !== pa[7:0] ||
          a_fc !== fa[7:0] || a_ri !== 8'd2 || b_rv !== 0 || b_st !== bst[1:0] || b_cc !== bcc[15:0] || b_pc !== pb[7:0] || b_fc !== fb[7:0]) begin
        failures++;
        $display("FAIL hold done=%b rv=%b busy=%b st=%0d cc=%0d pc=%0d fc=%0d ri=%0d b_pc=%0d b_fc=%0d want 0 0 0 %0d %0d %0d %0d 2 %0d %0d",
                 a_done, a_rv, a_busy, a_st, a_cc, a_pc, a_fc, a_ri, b_pc, b_fc, est, ecnt, pa, fa, pb, fb);
      end
    end
    fin = 0; err = 0; stk = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (a_rst_n !== 0 || a_busy !== 0 || a_rv !== 0 || a_st !== 0 || a_cc !== 0 || a_ri !== 0 || a_pc !== 0 ||
        a_fc !== 0 || a_done !== 0 || b_rst_n !== 0 || b_busy !== 0) begin
      failures++; $display("FAIL reset rst_n=%b busy=%b rv=%b st=%0d cc=%0d ri=%0d pc=%0d fc=%0d done=%b want all 0",
                           a_rst_n, a_busy, a_rv, a_st, a_cc, a_ri, a_pc, a_fc, a_done);
    end
    rst = 0; fin = 1; err = 1;
    repeat (5) @(negedge clk);
    checks++;
    if (a_rv !== 0 || a_busy !== 0 || a_rst_n !== 0 || a_fc !== 0) begin
      failures++; $display("FAIL idle_ignore rv=%b busy=%b rst_n=%b fc=%0d want 0 0 0 0", a_rv, a_busy, a_rst_n, a_fc);
    end
    fin = 0; err = 0;
  endtask

  task automatic test_pass;
    kind = '{3'b001, 3'b001, 3'b001}; cyc = '{10, 1, 5};
    run_seq(1);
  endtask

  task automatic test_error_priority;
    kind = '{3'b101, 3'b001, 3'b001}; cyc = '{7, 2, 3};
    run_seq(0);
  endtask

  task automatic test_stack;
    kind = '{3'b011, 3'b010, 3'b001}; cyc = '{4, 15, 20};
    run_seq(0);
  endtask

  task automatic test_timeout;
    kind = '{3'b000, 3'b001, 3'b100}; cyc = '{1, 21, 20};
    run_seq(0);
  endtask

  task automatic test_multi;
    kind = '{3'b001, 3'b100, 3'b001}; cyc = '{6, 9, 12};
    run_seq(1);
  endtask

  task automatic test_random;
    for (int s = 0; s < 6; s++) begin
      for (int r = 0; r < 3; r++) begin
        kind[r] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b001;
        cyc[r] = $urandom_range(1, 24);
      end
      run_seq(s[0]);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    bit bad;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    n = 0;
    while (a_rst_n === 1'b0 && n < 50) begin n++; @(negedge clk); end
    repeat (3) @(negedge clk);
    checks++;
    if (a_rst_n !== 1 || a_busy !== 1) begin
      failures++; $display("FAIL mid_running rst_n=%b busy=%b want 1 1", a_rst_n, a_busy);
    end
    rst = 1;
    @(negedge clk); rst = 0;
    checks++;
    if (a_rst_n !== 0 || a_busy !== 0 || a_rv !== 0 || a_done !== 0 || b_rst_n !== 0 || b_busy !== 0) begin
      failures++; $display("FAIL mid_reset rst_n=%b busy=%b rv=%b done=%b want 0 0 0 0", a_rst_n, a_busy, a_rv, a_done);
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      fin = i[0];
      @(negedge clk);
      if (a_rv !== 0 || a_done !== 0 || a_busy !== 0 || b_rv !== 0 || b_done !== 0) bad = 1;
    end
    fin = 0;
    checks++;
    if (bad) begin
      failures++; $display("FAIL mid_quiet pulse_seen=%b want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_error_priority();
    test_stack();
    test_timeout();
    test_multi();
    test_random();
    test_reset_mid();
    test_pass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
